// File: rtl/mm2017_pkg.sv
// rtl/mm2017_pkg.sv - shared types and width defaults for the MM2017 memory port arbiter.
package mm2017_pkg;

    localparam int MM_ADDR_W = 64;
    localparam int MM_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating incrementer with synchronous clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/DM arbiter and sequencer for the single unified memory port.
// Stall-cycle counters are built only when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter
    import mm2017_pkg::*;
#(
    parameter int ADDR_W = MM_ADDR_W,
    parameter int DATA_W = MM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall,
    output logic [31:0]       perf_if_stall,
    output logic [31:0]       perf_dm_stall
);

    arb_state_t state;
    owner_t     owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                IDLE: begin
                    // DM wins ties: it belongs to the older instruction in the pipe.
                    if (dm_req) begin
                        state     <= DATA;
                        owner     <= OWN_DM;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                    end else if (if_req) begin
                        state    <= FETCH;
                        owner    <= OWN_IF;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                    end
                end
                FETCH, DATA: begin
                    if (mem_ready) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        if (owner == OWN_DM) begin
                            dm_rdata <= mem_rdata;
                            dm_ack   <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ack   <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign stall = (if_req & ~if_ack) | (dm_req & ~dm_ack);

`ifdef MEM_ARB_PERF_EN
    sat_counter #(
        .W(32)
    ) u_if_stall_cnt (
        .clk  (clk),
        .clr  (rst),
        .inc  (if_req & ~if_ack),
        .count(perf_if_stall)
    );

    sat_counter #(
        .W(32)
    ) u_dm_stall_cnt (
        .clk  (clk),
        .clr  (rst),
        .inc  (dm_req & ~dm_ack),
        .count(perf_dm_stall)
    );
`else
    assign perf_if_stall = '0;
    assign perf_dm_stall = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with a timestamp-based model.
module tb_mem_port_arbiter;
    import mm2017_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic [63:0] if_rdata;
    logic        if_ack;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [63:0] dm_addr = '0;
    logic [63:0] dm_wdata = '0;
    logic [63:0] dm_rdata;
    logic        dm_ack;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        stall;
    logic [31:0] perf_if_stall;
    logic [31:0] perf_dm_stall;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(64),
        .DATA_W(64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rdata     (if_rdata),
        .if_ack       (if_ack),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_rdata     (dm_rdata),
        .dm_ack       (dm_ack),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .stall        (stall),
        .perf_if_stall(perf_if_stall),
        .perf_dm_stall(perf_dm_stall)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: a transaction is described by its grant cycle and the cycle memory answered.
    int          cyc = 0;
    int          g_cyc = -1;
    int          r_cyc = -1;
    bit          m_dm = 1'b0;
    logic [63:0] m_addr = '0;
    logic        m_we = 1'b0;
    logic [63:0] m_wdata = '0;
    logic [63:0] m_if_rdata = '0;
    logic [63:0] m_dm_rdata = '0;
    logic [31:0] m_perf_if = '0;
    logic [31:0] m_perf_dm = '0;

    function automatic bit m_idle(input int c);
        return (g_cyc < 0) || (r_cyc >= 0 && c >= r_cyc + 2);
    endfunction

    function automatic bit m_access(input int c);
        return (g_cyc >= 0) && (c > g_cyc) && (r_cyc < 0 || c <= r_cyc);
    endfunction

    function automatic bit m_resp(input int c);
        return (r_cyc >= 0) && (c == r_cyc + 1);
    endfunction

    always @(posedge clk) begin
        bit ia;
        bit da;
        ia = m_resp(cyc) && !m_dm;
        da = m_resp(cyc) && m_dm;
        if (rst) begin
            g_cyc = -1; r_cyc = -1; m_dm = 1'b0;
            m_addr = '0; m_we = 1'b0; m_wdata = '0;
            m_if_rdata = '0; m_dm_rdata = '0;
        end else if (m_idle(cyc)) begin
            if (dm_req || if_req) begin
                g_cyc  = cyc;
                r_cyc  = -1;
                m_dm   = dm_req;
                m_addr = dm_req ? dm_addr : if_addr;
                m_we   = dm_req && dm_we;
                if (dm_req) m_wdata = dm_wdata;
            end else begin
                g_cyc = -1;
            end
        end else if (m_access(cyc) && mem_ready) begin
            r_cyc = cyc;
            if (m_dm) m_dm_rdata = mem_rdata;
            else      m_if_rdata = mem_rdata;
        end
`ifdef MEM_ARB_PERF_EN
        if (rst) begin
            m_perf_if = '0;
            m_perf_dm = '0;
        end else begin
            if (if_req && !ia && m_perf_if != 32'hFFFF_FFFF) m_perf_if = m_perf_if + 1;
            if (dm_req && !da && m_perf_dm != 32'hFFFF_FFFF) m_perf_dm = m_perf_dm + 1;
        end
`endif
        cyc++;
    end

    always @(negedge clk) begin
        bit acc;
        bit ia;
        bit da;
        if (chk_en) begin
            acc = m_access(cyc);
            ia  = m_resp(cyc) && !m_dm;
            da  = m_resp(cyc) && m_dm;
            check("mem_req", mem_req, acc);
            check("if_ack", if_ack, ia);
            check("dm_ack", dm_ack, da);
            check("if_rdata", if_rdata, m_if_rdata);
            check("dm_rdata", dm_rdata, m_dm_rdata);
            if (acc) begin
                check("mem_addr", mem_addr, m_addr);
                check("mem_we", mem_we, m_we);
                if (m_we) check("mem_wdata", mem_wdata, m_wdata);
            end
            check("stall", stall, (if_req && !ia) || (dm_req && !da));
            check("perf_if_stall", perf_if_stall, m_perf_if);
            check("perf_dm_stall", perf_dm_stall, m_perf_dm);
        end
    end

    // Applies one cycle of stimulus and returns mid-cycle, after outputs have settled.
    task automatic tick(input logic r, input logic ir, input logic dr, input logic mr,
                        input logic [63:0] rd);
        @(posedge clk);
        #2;
        rst = r; if_req = ir; dm_req = dr; mem_ready = mr; mem_rdata = rd;
        @(negedge clk);
        #1;
    endtask

    initial begin
        tick(1, 0, 0, 0, 64'h0);
        tick(1, 0, 0, 0, 64'h0);
        chk_en = 1'b1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_if_rdata", if_rdata, 64'h0);
        check("rst_mem_addr", mem_addr, 64'h0);
        tick(0, 0, 0, 0, 64'h0);

        // Fetch, zero-wait memory.
        if_addr = 64'h40;
        tick(0, 1, 0, 0, 64'h0);
        tick(0, 1, 0, 1, 64'h8B02_0020);
        check("t1_mem_req_c1", mem_req, 1'b1);
        check("t1_mem_addr_c1", mem_addr, 64'h40);
        tick(0, 1, 0, 0, 64'h0);
        check("t1_if_ack_c2", if_ack, 1'b1);
        check("t1_if_rdata_c2", if_rdata, 64'h8B02_0020);
        tick(0, 0, 0, 0, 64'h0);
        check("t1_stall_c3", stall, 1'b0);
        check("t1_if_ack_c3", if_ack, 1'b0);

        // Simultaneous requests: DM load first, then the fetch.
        if_addr = 64'h80; dm_addr = 64'h1000; dm_we = 1'b0;
        tick(0, 1, 1, 0, 64'h0);
        check("t2_stall_c0", stall, 1'b1);
        tick(0, 1, 1, 1, 64'h1111);
        check("t2_mem_addr_c1", mem_addr, 64'h1000);
        tick(0, 1, 1, 0, 64'h0);
        check("t2_dm_ack_c2", dm_ack, 1'b1);
        check("t2_dm_rdata_c2", dm_rdata, 64'h1111);
        tick(0, 1, 0, 0, 64'h0);
        tick(0, 1, 0, 1, 64'h2222);
        check("t2_mem_addr_c4", mem_addr, 64'h80);
        check("t2_mem_we_c4", mem_we, 1'b0);
        check("t2_stall_c4", stall, 1'b1);
        tick(0, 1, 0, 0, 64'h0);
        check("t2_if_ack_c5", if_ack, 1'b1);
        check("t2_stall_c5", stall, 1'b0);
        tick(0, 0, 0, 0, 64'h0);

        // Store with three memory wait cycles; requester inputs wiggle mid-access.
        dm_addr = 64'h2008; dm_wdata = 64'hDEAD_BEEF; dm_we = 1'b1;
        tick(0, 0, 1, 0, 64'h0);
        for (int i = 1; i <= 4; i++) begin
            tick(0, 0, 1, (i == 4), 64'h3333);
            check("t3_mem_we", mem_we, 1'b1);
            check("t3_mem_wdata", mem_wdata, 64'hDEAD_BEEF);
            check("t3_mem_addr", mem_addr, 64'h2008);
            dm_addr = 64'h9999; dm_wdata = 64'h1234; dm_we = 1'b0;
        end
        tick(0, 0, 1, 0, 64'h0);
        check("t3_dm_ack_c5", dm_ack, 1'b1);
        tick(0, 0, 0, 0, 64'h0);

        // DM arriving during a fetch waits, then beats a fresh fetch request.
        if_addr = 64'h100; dm_addr = 64'h3000; dm_we = 1'b0;
        tick(0, 1, 0, 0, 64'h0);
        tick(0, 1, 1, 0, 64'h0);
        tick(0, 1, 1, 1, 64'h4444);
        tick(0, 1, 1, 0, 64'h0);
        check("t4_if_ack", if_ack, 1'b1);
        if_addr = 64'h108;
        tick(0, 1, 1, 0, 64'h0);
        tick(0, 1, 1, 1, 64'h5555);
        check("t4_dm_first", mem_addr, 64'h3000);
        tick(0, 1, 1, 0, 64'h0);
        tick(0, 1, 0, 0, 64'h0);
        tick(0, 1, 0, 1, 64'h6666);
        check("t4_fetch_addr", mem_addr, 64'h108);
        tick(0, 1, 0, 0, 64'h0);
        tick(0, 0, 0, 0, 64'h0);

        // Reset in the second access cycle of a long fetch.
        if_addr = 64'h200;
        tick(0, 1, 0, 0, 64'h0);
        tick(0, 1, 0, 0, 64'h0);
        tick(1, 1, 0, 0, 64'h0);
        check("t5_mem_req_c2", mem_req, 1'b1);
        tick(0, 0, 0, 1, 64'h7777);
        check("t5_mem_req_c3", mem_req, 1'b0);
        check("t5_mem_addr_c3", mem_addr, 64'h0);
        check("t5_if_rdata_c3", if_rdata, 64'h0);
        check("t5_dm_rdata_c3", dm_rdata, 64'h0);
        check("t5_perf_dm_c3", perf_dm_stall, 32'h0);
        tick(0, 0, 0, 0, 64'h0);
        check("t5_no_ack_c4", if_ack, 1'b0);
        if_addr = 64'h204;
        tick(0, 1, 0, 0, 64'h0);
        tick(0, 1, 0, 1, 64'hABCD);
        tick(0, 1, 0, 0, 64'h0);
        check("t5_refetch_ack", if_ack, 1'b1);
        check("t5_refetch_data", if_rdata, 64'hABCD);
        tick(0, 0, 0, 0, 64'h0);

        // Stray mem_ready in IDLE and RESP.
        tick(0, 0, 0, 1, 64'hBAD0);
        tick(0, 0, 0, 1, 64'hBAD1);
        check("t6_idle_ack", if_ack, 1'b0);
        check("t6_idle_rdata", if_rdata, 64'hABCD);
        if_addr = 64'h300;
        tick(0, 1, 0, 0, 64'h0);
        tick(0, 1, 0, 1, 64'h5A5A);
        tick(0, 1, 0, 1, 64'hBAD2);
        check("t6_resp_data", if_rdata, 64'h5A5A);
        tick(0, 0, 0, 1, 64'hBAD3);
        check("t6_after_resp_data", if_rdata, 64'h5A5A);
        check("t6_after_resp_req", mem_req, 1'b0);
        tick(0, 0, 0, 0, 64'h0);

`ifdef MEM_ARB_PERF_EN
        force dut.u_dm_stall_cnt.count = 32'hFFFF_FFFE;
        m_perf_dm = 32'hFFFF_FFFE;
        tick(0, 0, 0, 0, 64'h0);
        release dut.u_dm_stall_cnt.count;
        dm_addr = 64'h4000; dm_we = 1'b0;
        tick(0, 0, 1, 0, 64'h0);
        tick(0, 0, 1, 0, 64'h0);
        tick(0, 0, 1, 0, 64'h0);
        tick(0, 0, 1, 1, 64'h1);
        tick(0, 0, 1, 0, 64'h0);
        check("t7_perf_dm_sat", perf_dm_stall, 32'hFFFF_FFFF);
        tick(0, 0, 0, 0, 64'h0);
`else
        check("t7_perf_if_zero", perf_if_stall, 32'h0);
        check("t7_perf_dm_zero", perf_dm_stall, 32'h0);
`endif

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the single unified memory port of the MM2017 ARMv8 core. Shares the port between the instruction-fetch stage (IF) and the data-memory stage (DM). Serializes their requests through a small state machine with a request/acknowledge handshake, and drives the pipeline-wide stall. Sits between the IF/MEM pipeline stages and the memory model, under the top-level `MM2017` module.

## Interface
Parameters:
- `ADDR_W`, 64: address width.
- `DATA_W`, 64: data width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset. Synchronous, active-high.
- `if_req`  in  1: fetch request; held until `if_ack`.
- `if_addr`  in  ADDR_W: fetch address (PC).
- `if_rdata`  out  DATA_W: fetched word, valid while `if_ack`.
- `if_ack`  out  1: one-cycle fetch completion pulse.
- `dm_req`  in  1: data request; held until `dm_ack`.
- `dm_we`  in  1: 1 = store, 0 = load.
- `dm_addr`  in  ADDR_W: data address.
- `dm_wdata`  in  DATA_W: store data.
- `dm_rdata`  out  DATA_W: load data, valid while `dm_ack`.
- `dm_ack`  out  1: one-cycle data completion pulse.
- `mem_req`  out  1: memory access in progress.
- `mem_we`  out  1: write enable to memory.
- `mem_addr`  out  ADDR_W: memory address.
- `mem_wdata`  out  DATA_W: memory write data.
- `mem_rdata`  in  DATA_W: memory read data, valid with `mem_ready`.
- `mem_ready`  in  1: memory completes the current access this cycle.
- `stall`  out  1: pipeline stall.
- `perf_if_stall`  out  32: fetch stall-cycle count.
- `perf_dm_stall`  out  32: data stall-cycle count.

## Operation
- The FSM has four states: IDLE, FETCH, DATA and RESP.
- **IDLE**
  - If `dm_req`: go to DATA. DM has priority because it belongs to the older instruction.
  - Else if `if_req`: go to FETCH.
  - On the same edge, latch the address, and for data also `dm_we` and `dm_wdata`, into the `mem_*` registers.
- **FETCH / DATA**
  - `mem_req` = 1; `mem_addr`, `mem_we` and `mem_wdata` stay stable.
  - `mem_we` is forced to 0 in FETCH.
  - On `mem_ready`: capture `mem_rdata` into `if_rdata` or `dm_rdata`, record the owner, and go to RESP.
  - Changes on the requester inputs during the access are ignored.
- **RESP**
  - Assert the owner's ack for exactly one cycle; `mem_req` = 0.
  - Next state is always IDLE.
  - Requesters update `req` at the RESP edge, so IDLE never re-grants a request that was just acknowledged.
- `dm_rdata` on a store holds the value captured from `mem_rdata`; don't-care for requesters.
- Read-data registers hold their last value until the next capture.
- `stall` = (`if_req` & !`if_ack`) | (`dm_req` & !`dm_ack`). This is combinational from registered state and inputs.
- `mem_ready` in IDLE or RESP is ignored.
- A `dm_req` arriving while FETCH is in progress waits. It is granted at the next IDLE even if `if_req` is also high.
- Fetch can starve under continuous DM traffic. This is acceptable: the stall freezes IF's producer.

## Timing
- Reset values: state IDLE; `mem_req`, `mem_we`, `if_ack`, `dm_ack` = 0; `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata` = 0; perf counters = 0.
- With a zero-wait memory (`mem_ready` in the first access cycle):
  - request sampled in IDLE at cycle 0;
  - access at cycle 1;
  - ack at cycle 2;
  - IDLE at cycle 3.
- Minimum 3 cycles per access; each memory wait cycle adds one.
- Back-to-back accesses: throughput is one access per (3 + waits) cycles.
- Reset mid-access: state returns to IDLE on that edge, the transaction is abandoned, and no ack is issued. The memory shares `rst`.

## Configuration
- Macro `MEM_ARB_PERF_EN`.
- Defined:
  - `perf_if_stall` increments each cycle `if_req` & !`if_ack`.
  - `perf_dm_stall` increments each cycle `dm_req` & !`dm_ack`.
  - Both saturate at 0xFFFF_FFFF and clear on `rst`.
- Undefined: no counter logic; both outputs are constant 0.

## Structure
- Package `mm2017_pkg` holds:
  - the FSM state typedef (IDLE, FETCH, DATA, RESP);
  - the owner encoding;
  - `MM_ADDR_W` / `MM_DATA_W` constants, which are the parameter defaults.
- One sub-module, `sat_counter` (32-bit saturating incrementer with synchronous clear), instantiated twice under `MEM_ARB_PERF_EN`.

## Test plan
- Fetch only, zero-wait memory, `if_addr`=0x40, `mem_rdata`=0x8B020020 → `mem_req` high in cycle 1, `if_ack` pulses in cycle 2 with `if_rdata`=0x8B020020, `stall` low from cycle 3.
- Simultaneous `if_req` and `dm_req` (load, `dm_addr`=0x1000) → DATA granted first; `mem_addr`=0x1000 and `dm_ack` at cycle 2; then FETCH with `if_ack` at cycle 5; `stall` high cycles 0–4.
- Store `dm_addr`=0x2008, `dm_wdata`=0xDEADBEEF, memory ready after 3 waits → `mem_we`=1 and `mem_wdata`=0xDEADBEEF held 4 cycles; `dm_ack` at cycle 5; `mem_we`=0 during any FETCH.
- `rst` asserted during cycle 2 of a 5-wait fetch → next cycle all outputs at reset values, no `if_ack`; a new `if_req` is served normally afterwards.
- Stray `mem_ready` pulses in IDLE and RESP → no ack, no state change, read-data registers unchanged.
- With `MEM_ARB_PERF_EN`, `perf_dm_stall` preloaded via force to 0xFFFF_FFFE, 4 stall cycles → counter reads 0xFFFF_FFFF. Without the macro, both counters stay 0 throughout.
